uart_tx_arbiter: RTL and testbench

//  Shares the single UART transmitter among N_REQ byte-stream requesters (command replies, PWM status, debug).

---
 rtl/uart_arb_pkg.sv | 27 ++
 rtl/rr_pick.sv | 29 ++
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 361 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int unsigned BYTE_W            = 8;
    localparam int unsigned STALL_MAX_DEFAULT = 1024;

    typedef enum logic [0:0] {
        StIdle,
        StXfer
    } arb_state_e;

    // Round-robin pointer after 'owner' releases the UART. With skip_zero, requester 0 sits
    // outside the rotation: the pointer never lands on 0 and a packet from 0 leaves it alone.
    function automatic int unsigned next_rr_ptr(int unsigned owner, int unsigned cur_ptr,
                                                int unsigned n_req, bit skip_zero);
        int unsigned nxt;
        if (skip_zero && owner == 0) begin
            return cur_ptr;
        end
        nxt = (owner + 1) % n_req;
        if (skip_zero && nxt == 0) begin
            nxt = 1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority encoder: index of the first set request at or after ptr_i, wrapping.
module rr_pick
    import uart_arb_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = $clog2(N)
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [IdxW-1:0] idx_o,
    output logic            found_o
);

    // Scan offsets 0..N-1 from the pointer; the first hit wins.
    always_comb begin
        int unsigned j;
        j       = 0;
        idx_o   = '0;
        found_o = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (32'(ptr_i) + k) % N;
            if (!found_o && req_i[IdxW'(j)]) begin
                found_o = 1'b1;
                idx_o   = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among N_REQ requesters,
// with a watchdog that releases an owner stalled mid-packet.
// Optional build macro UART_TX_ARB_PRIO0_EN: requester 0 becomes strict priority and the
// round-robin rotation covers only requesters 1..N_REQ-1.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int unsigned N_REQ     = 4,
    parameter int unsigned STALL_MAX = STALL_MAX_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [BYTE_W*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]          req_last_i,
    output logic [N_REQ-1:0]          req_ready_o,
    output logic                      tx_valid_o,
    output logic [BYTE_W-1:0]         tx_data_o,
    input  logic                      tx_ready_i,
    output logic [$clog2(N_REQ)-1:0]  grant_id_o,
    output logic                      busy_o,
    output logic                      abort_o
);

    localparam int unsigned IdxW = $clog2(N_REQ);
    localparam int unsigned CntW = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
    localparam logic [CntW-1:0] StallLast = CntW'(STALL_MAX - 1);

`ifdef UART_TX_ARB_PRIO0_EN
    localparam bit SkipZero = 1'b1;
`else
    localparam bit SkipZero = 1'b0;
`endif

    arb_state_e      state_q, state_d;
    logic [IdxW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic [CntW-1:0] stall_q, stall_d;
    logic            abort_q, abort_d;

    logic [N_REQ-1:0]  pick_req;
    logic [IdxW-1:0]   pick_idx;
    logic              pick_found;
    logic [IdxW-1:0]   win_idx;
    logic              win_found;

    logic [N_REQ-1:0]  own_sel;
    logic              own_valid;
    logic              own_last;
    logic [BYTE_W-1:0] own_data;
    logic [IdxW-1:0]   ptr_after;

`ifdef UART_TX_ARB_PRIO0_EN
    // Requester 0 is handled outside the rotation.
    assign pick_req = {req_valid_i[N_REQ-1:1], 1'b0};
`else
    assign pick_req = req_valid_i;
`endif

    rr_pick #(
        .N    (N_REQ),
        .IdxW (IdxW)
    ) u_rr_pick (
        .req_i   (pick_req),
        .ptr_i   (rr_ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // Arbitration winner, with the optional strict-priority override for requester 0.
    always_comb begin
        win_idx   = pick_idx;
        win_found = pick_found;
`ifdef UART_TX_ARB_PRIO0_EN
        if (req_valid_i[0]) begin
            win_idx   = '0;
            win_found = 1'b1;
        end
`endif
    end

    // Select the current owner's request lines; a mux loop keeps indices in range.
    always_comb begin
        own_sel   = '0;
        own_valid = 1'b0;
        own_last  = 1'b0;
        own_data  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_q == IdxW'(i)) begin
                own_sel[i] = 1'b1;
                own_valid  = req_valid_i[i];
                own_last   = req_last_i[i];
                own_data   = req_data_i[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign ptr_after = IdxW'(next_rr_ptr(32'(grant_q), 32'(rr_ptr_q), N_REQ, SkipZero));

    // Next-state logic and handshake muxing.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        stall_d     = stall_q;
        abort_d     = 1'b0;
        tx_valid_o  = 1'b0;
        tx_data_o   = '0;
        req_ready_o = '0;

        unique case (state_q)
            StIdle: begin
                stall_d = '0;
                if (win_found) begin
                    grant_d = win_idx;
                    state_d = StXfer;
                end
            end
            StXfer: begin
                tx_valid_o  = own_valid;
                tx_data_o   = own_data;
                req_ready_o = own_sel & {N_REQ{tx_ready_i}};
                if (own_valid) begin
                    // A present byte is not a stall even if the UART is back-pressuring.
                    stall_d = '0;
                    if (tx_ready_i && own_last) begin
                        rr_ptr_d = ptr_after;
                        state_d  = StIdle;
                    end
                end else if (stall_q == StallLast) begin
                    abort_d  = 1'b1;
                    stall_d  = '0;
                    rr_ptr_d = ptr_after;
                    state_d  = StIdle;
                end else begin
                    stall_d = stall_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            stall_q  <= '0;
            abort_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            stall_q  <= stall_d;
            abort_q  <= abort_d;
        end
    end

    assign busy_o     = (state_q == StXfer);
    assign grant_id_o = grant_q;
    assign abort_o    = abort_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus a randomized run, checked
// every cycle against a packet/queue-level reference model of the arbitration rules.
module tb_uart_tx_arbiter;
    import uart_arb_pkg::*;

    localparam int N     = 4;
    localparam int STALL = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid, req_last, req_ready;
    logic [8*N-1:0] req_data;
    logic           tx_valid, tx_ready;
    logic [7:0]     tx_data;
    logic [1:0]     grant_id;
    logic           busy, abort;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ     (N),
        .STALL_MAX (STALL)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_ready_i  (tx_ready),
        .grant_id_o  (grant_id),
        .busy_o      (busy),
        .abort_o     (abort)
    );

    int checks = 0;
    int errors = 0;

    // Requester byte queues: bit 8 = last flag. en gates req_valid to create stalls.
    logic [8:0] q [N][$];
    bit         en [N];

    // Reference model: owner (or none), pointer, stall count, expected abort pulse.
    bit         m_busy;
    logic [1:0] m_gid;
    int         m_ptr;
    int         m_stall;
    bit         m_abort;

    int         cyc;
    int         hs_own [$];
    logic [7:0] hs_dat [$];
    int         hs_cyc [$];
    int         abort_seen;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(logic [N-1:0] v);
`ifdef UART_TX_ARB_PRIO0_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            int j;
            j = (m_ptr + k) % N;
`ifdef UART_TX_ARB_PRIO0_EN
            if (j == 0) continue;
`endif
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic int after(logic [1:0] g);
        int n;
        n = (int'(g) + 1) % N;
`ifdef UART_TX_ARB_PRIO0_EN
        if (g == 2'd0) return m_ptr;
        if (n == 0) n = 1;
`endif
        return n;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (q[i].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            if (en[i] && q[i].size() > 0) begin
                req_valid[i]        = 1'b1;
                req_data[8*i +: 8]  = q[i][0][7:0];
                req_last[i]         = q[i][0][8];
            end else begin
                req_valid[i]        = 1'b0;
                req_data[8*i +: 8]  = 8'($urandom);
                req_last[i]         = 1'($urandom);
            end
        end
    endtask

    // One clock cycle: drive, check against the model, clock, update requesters and model.
    task automatic tick();
        logic [N-1:0] v, l, rdy, exp_rdy;
        bit           tr, rc, exp_tv, nab, done;
        int           p;
        logic [8:0]   b;
        apply();
        #2;
        chk("busy", 32'(busy), 32'(m_busy));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("abort", 32'(abort), 32'(m_abort));
        exp_tv = m_busy && req_valid[m_gid];
        chk("tx_valid", 32'(tx_valid), 32'(exp_tv));
        if (exp_tv) chk("tx_data", 32'(tx_data), 32'(q[m_gid][0][7:0]));
        exp_rdy = '0;
        if (m_busy) exp_rdy[m_gid] = tx_ready;
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (abort) abort_seen++;
        if (tx_valid && tx_ready) begin
            hs_own.push_back(int'(grant_id));
            hs_dat.push_back(tx_data);
            hs_cyc.push_back(cyc);
        end
        v = req_valid; l = req_last; rdy = req_ready; tr = tx_ready; rc = rst;
        @(posedge clk);
        cyc++;
        for (int i = 0; i < N; i++) if (v[i] && rdy[i]) void'(q[i].pop_front());
        nab = 1'b0;
        if (rc) begin
            m_busy = 0; m_ptr = 0; m_gid = 2'd0; m_stall = 0;
        end else if (!m_busy) begin
            p = pick(v);
            if (p >= 0) begin
                m_busy = 1; m_gid = 2'(p); m_stall = 0;
            end
        end else if (v[m_gid]) begin
            m_stall = 0;
            if (tr && l[m_gid]) begin
                m_busy = 0; m_ptr = after(m_gid);
            end
        end else if (m_stall == STALL - 1) begin
            nab = 1; m_busy = 0; m_ptr = after(m_gid); m_stall = 0;
            // The stalled requester abandons the rest of its packet.
            done = 1'b0;
            while (!done && q[m_gid].size() > 0) begin
                b    = q[m_gid].pop_front();
                done = b[8];
            end
        end else begin
            m_stall++;
        end
        m_abort = nab;
        #1;
    endtask

    task automatic clear_log();
        hs_own.delete(); hs_dat.delete(); hs_cyc.delete();
        abort_seen = 0;
    endtask

    task automatic do_reset();
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            en[i] = 1'b1;
        end
        tx_ready = 1'b1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        clear_log();
    endtask

    task automatic push_pkt(int r, int len, logic [7:0] base);
        for (int k = 0; k < len; k++) q[r].push_back({k == len - 1, base + 8'(k)});
    endtask

    task automatic run_drain(string tag, int budget);
        int n;
        n = 0;
        while ((pending() || busy) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        assert (n < budget) else begin
            errors++;
            $error("FAIL %s_timeout: observed=%0d cycles expected=<%0d", tag, n, budget);
        end
    endtask

    initial begin
        int n;
        // Bring the DUT out of X before the model is trusted.
        for (int i = 0; i < N; i++) en[i] = 1'b1;
        tx_ready = 1'b1;
        rst = 1'b1;
        cyc = 0;
        apply();
        repeat (2) @(posedge clk);
        m_busy = 0; m_gid = 2'd0; m_ptr = 0; m_stall = 0; m_abort = 0;
        #1;
        rst = 1'b0;
        clear_log();

        // Reset values.
        apply();
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant_id), 32'd0);
        chk("rst_abort", 32'(abort), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);

        // Single requester 1, three bytes.
        do_reset();
        q[1].push_back(9'h0A1); q[1].push_back(9'h0A2); q[1].push_back(9'h1A3);
        tick();
        apply();
        #2;
        chk("t1_grant_busy", 32'(busy), 32'd1);
        chk("t1_grant_id", 32'(grant_id), 32'd1);
        run_drain("t1", 50);
        chk("t1_count", 32'(hs_dat.size()), 32'd3);
        if (hs_dat.size() == 3) begin
            chk("t1_b0", 32'(hs_dat[0]), 32'hA1);
            chk("t1_b1", 32'(hs_dat[1]), 32'hA2);
            chk("t1_b2", 32'(hs_dat[2]), 32'hA3);
        end

        // All four requesters, 2-byte packets, requester 0 with two packets.
        do_reset();
        for (int r = 0; r < N; r++) push_pkt(r, 2, 8'(16 * r + 16));
        push_pkt(0, 2, 8'h80);
        run_drain("t2", 100);
        chk("t2_count", 32'(hs_dat.size()), 32'd10);
`ifndef UART_TX_ARB_PRIO0_EN
        if (hs_dat.size() == 10) begin
            for (int k = 0; k < 5; k++) begin
                chk("t2_order", 32'(hs_own[2*k]), 32'(k % N));
                chk("t2_inpkt_gap", 32'(hs_cyc[2*k+1] - hs_cyc[2*k]), 32'd1);
                if (k > 0) chk("t2_idle_gap", 32'(hs_cyc[2*k] - hs_cyc[2*k-1]), 32'd2);
            end
        end
`endif

        // Requester 0 arrives during a requester 2 packet; 3 waits there too.
        do_reset();
        push_pkt(2, 4, 8'h20);
        repeat (3) tick();
        push_pkt(0, 2, 8'h00);
        push_pkt(3, 2, 8'h30);
        run_drain("t3", 100);
        chk("t3_count", 32'(hs_dat.size()), 32'd8);
`ifndef UART_TX_ARB_PRIO0_EN
        if (hs_dat.size() == 8) begin
            for (int k = 0; k < 4; k++) chk("t3_owner2", 32'(hs_own[k]), 32'd2);
            chk("t3_then3", 32'(hs_own[4]), 32'd3);
            chk("t3_then0", 32'(hs_own[6]), 32'd0);
        end
`endif

        // Long tx_ready back-pressure with the owner still valid: no watchdog.
        do_reset();
        push_pkt(2, 3, 8'h31);
        repeat (2) tick();
        tx_ready = 1'b0;
        repeat (5000) tick();
        tx_ready = 1'b1;
        run_drain("t4", 50);
        chk("t4_no_abort", 32'(abort_seen), 32'd0);
        chk("t4_count", 32'(hs_dat.size()), 32'd3);
        if (hs_dat.size() == 3) begin
            chk("t4_b0", 32'(hs_dat[0]), 32'h31);
            chk("t4_b1", 32'(hs_dat[1]), 32'h32);
            chk("t4_b2", 32'(hs_dat[2]), 32'h33);
        end

        // Owner 1 stalls after its first byte; watchdog releases, requester 2 follows.
        do_reset();
        push_pkt(1, 3, 8'h41);
        push_pkt(2, 1, 8'h51);
        repeat (2) tick();
        en[1] = 1'b0;
        n = 0;
        while (abort_seen == 0 && n < 40) begin
            tick();
            n++;
        end
        chk("t5_abort_cycle", 32'(n), 32'(STALL + 1));
        tick();
        chk("t5_next_grant", 32'(grant_id), 32'd2);
        en[1] = 1'b1;
        run_drain("t5", 50);
        chk("t5_abort_once", 32'(abort_seen), 32'd1);
        chk("t5_count", 32'(hs_dat.size()), 32'd2);
        if (hs_dat.size() == 2) begin
            chk("t5_own0", 32'(hs_own[0]), 32'd1);
            chk("t5_own1", 32'(hs_own[1]), 32'd2);
            chk("t5_b1", 32'(hs_dat[1]), 32'h51);
        end

        // Reset in the middle of a requester 3 packet.
        do_reset();
        push_pkt(3, 4, 8'h60);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        apply();
        #2;
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_grant", 32'(grant_id), 32'd0);
        chk("t6_tx_valid", 32'(tx_valid), 32'd0);
        chk("t6_req_ready", 32'(req_ready), 32'd0);
        chk("t6_abort", 32'(abort), 32'd0);
        for (int i = 0; i < N; i++) q[i].delete();
        tick();

`ifdef UART_TX_ARB_PRIO0_EN
        // Strict priority for requester 0 from IDLE.
        do_reset();
        push_pkt(3, 2, 8'h70);
        push_pkt(0, 2, 8'h08);
        tick();
        chk("t7_prio_grant", 32'(grant_id), 32'd0);
        run_drain("t7", 50);
`endif

        // Randomized traffic with gaps and back-pressure.
        do_reset();
        for (int round = 0; round < 3; round++) begin
            for (int r = 0; r < N; r++) begin
                for (int p = 0; p < int'($urandom_range(1, 2)); p++) begin
                    push_pkt(r, int'($urandom_range(1, 4)), 8'($urandom));
                end
            end
            n = 0;
            while ((pending() || busy) && n < 3000) begin
                for (int i = 0; i < N; i++) en[i] = ($urandom_range(0, 5) != 0);
                tx_ready = ($urandom_range(0, 3) != 0);
                tick();
                n++;
            end
            chk("t8_drained", 32'(pending()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
